first_hit_locator: RTL and testbench
====================================

# first_hit_locator

Pipelined, parametrised priority encoder for the FRB trigger path. It reports, for every valid input word, the index of the first set bit, in either LSB-first or MSB-first order. It also tracks fixed-length frames of words and reports the earliest hit in each frame as a (word, bit) timestamp. It sits between the threshold comparator bank and the timestamp/packetiser logic.

## Interface
- DIN_WIDTH, 32, input word width; power of two, ≥ 8
- SEG_WIDTH, 8, bits per first-stage segment; power of two, divides DIN_WIDTH
- FRAME_LEN, 1024, words per frame; power of two, ≥ 2
- IDX_WIDTH, $clog2(DIN_WIDTH), bit-index width
- CNT_WIDTH, $clog2(FRAME_LEN), word-counter width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  DIN_WIDTH  input word
- din_valid  in  1  din qualifier
- msb_first  in  1  order select: 1 = highest set bit wins, 0 = lowest; sampled with din
- sof  in  1  start of frame; meaningful only with din_valid
- dout_bit  out  IDX_WIDTH  per-word first-set-bit index
- dout_found  out  1  per-word: any bit set
- dout_valid  out  1  per-word result strobe
- frame_word  out  CNT_WIDTH  word offset of first hit in frame
- frame_bit  out  IDX_WIDTH  bit index of first hit in that word
- frame_found  out  1  frame contained at least one hit
- frame_valid  out  1  one-cycle end-of-frame strobe

## Operation
- Stage 1: split din into DIN_WIDTH/SEG_WIDTH segments. For each segment, register a local index (both LSB- and MSB-first) and an any-bit flag. Also register the mode, valid and frame flags.
- Stage 2: select a segment by the registered mode (lowest or highest segment with any=1). Output index = seg*SEG_WIDTH + local index. dout_found = OR of the any flags.
- din == 0 gives dout_found=0 and dout_bit=0.
- Each word uses its own sampled msb_first. Mode changes take effect per word, with no flush.
- When dout_valid=0, dout_bit and dout_found hold their last values.
- Frame tracker states:
  - UNALIGNED: after reset, words are ignored by the frame path until the first sof.
  - RUN: word counter counts valid words from 0.
- Transitions:
  - sof in any state sets the counter to 0 for that word and clears the latch. A partially received frame is abandoned with no frame_valid.
  - When the counter reaches FRAME_LEN-1, the frame ends, the counter wraps to 0 and the next frame starts without needing sof. sof on a wrap word is consistent and has no extra effect.
- Latch: the first word in the frame with found=1 captures its counter value and bit index. Later hits are ignored.
- At frame end, frame_valid pulses with the latched values. With no hit: frame_found=0, frame_word=0, frame_bit=0.
- Counter arithmetic is unsigned CNT_WIDTH bits and wraps naturally.

## Timing
- Per-word latency: din/din_valid at edge t produces dout_* at t+2. Throughput is one word per cycle. There is no backpressure.
- Frame latency: the last word of a frame at t produces frame_valid at t+3, one cycle after its stage-2 result.
- A hit on the last word of a frame is included in that frame.
- A sof word at t+1 directly after the last word at t does not corrupt the pending frame report.
- Reset:
  - All outputs go to 0, the pipeline valids clear and the state returns to UNALIGNED.
  - Reset mid-frame discards the frame and any in-flight words. No frame_valid is produced for them.

## Structure
- Shared package frb_hit_pkg holds MODE_LSB=0 and MODE_MSB=1, the frame-state encodings, and a clog2 helper function.
- Sub-module seg_priority_encoder (SEG_WIDTH in; outputs lsb_idx, msb_idx, any; combinational). It is instantiated per segment and registered in the parent.
- The frame tracker lives in the parent module.

## Test plan
- Per-word path:
  - Stimulus: din=32'h0001_0100 with msb_first=0, then the same word with msb_first=1.
  - Required: dout_bit=8, then 16, both at t+2, dout_found=1.
- Zero word:
  - Stimulus: din=0 with valid.
  - Required: dout_found=0 and dout_bit=0.
  - Also: a valid gap holds the previous outputs and dout_valid=0.
- Frame with hits (FRAME_LEN=4):
  - Stimulus: sof on word 0; words 0 and 1 are zero; word 2 = 32'h80; word 3 = 32'h1.
  - Required: frame_valid at last-word+3 with frame_word=2, frame_bit=7, frame_found=1.
- Empty frame and auto-wrap:
  - Stimulus: four zero words after the previous frame, no sof.
  - Required: frame_valid with frame_found=0 and frame_word=0.
- Frame interruptions:
  - Stimulus: sof on word 2 of a frame; separately, rst asserted on word 1.
  - Required: no frame_valid for the abandoned frame. The next frame counts from the new sof. After rst, frames are ignored until a sof.
- Sweep: randomised single-hot and random words in both modes, checked against a reference model, with DIN_WIDTH=64 and SEG_WIDTH=16.

Source files
------------

// File: rtl/frb_hit_pkg.sv
// frb_hit_pkg: shared mode/frame-state encodings and clog2 helper for first_hit_locator
package frb_hit_pkg;
  localparam logic MODE_LSB = 1'b0;
  localparam logic MODE_MSB = 1'b1;
  typedef enum logic {UNALIGNED = 1'b0, RUN = 1'b1} frame_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/seg_priority_encoder.sv
// seg_priority_encoder: lowest/highest set-bit index and any flag for one segment
module seg_priority_encoder
  import frb_hit_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = W > 1 ? clog2(W) : 1
) (
  input  logic [W-1:0]  seg,
  output logic [IW-1:0] lsb_idx,
  output logic [IW-1:0] msb_idx,
  output logic          any
);
  always_comb begin
    lsb_idx = '0;
    msb_idx = '0;
    for (int i = W - 1; i >= 0; i--) lsb_idx = seg[i] ? IW'(i) : lsb_idx;
    for (int i = 0; i < W; i++) msb_idx = seg[i] ? IW'(i) : msb_idx;
  end
  assign any = |seg;
endmodule

// File: rtl/first_hit_locator.sv
// first_hit_locator: pipelined first-set-bit encoder with per-frame earliest-hit tracking
module first_hit_locator
  import frb_hit_pkg::*;
#(
  parameter int DIN_WIDTH = 32,
  parameter int SEG_WIDTH = 8,
  parameter int FRAME_LEN = 1024,
  parameter int IDX_WIDTH = clog2(DIN_WIDTH),
  parameter int CNT_WIDTH = clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 msb_first,
  input  logic                 sof,
  output logic [IDX_WIDTH-1:0] dout_bit,
  output logic                 dout_found,
  output logic                 dout_valid,
  output logic [CNT_WIDTH-1:0] frame_word,
  output logic [IDX_WIDTH-1:0] frame_bit,
  output logic                 frame_found,
  output logic                 frame_valid
);
  localparam int NSEG = DIN_WIDTH / SEG_WIDTH;
  localparam int SIW  = SEG_WIDTH > 1 ? clog2(SEG_WIDTH) : 1;
  logic [NSEG-1:0][SIW-1:0] lsb_d, lsb_q, msb_d, msb_q;
  logic [NSEG-1:0]          any_d, any_q;
  logic                     mode_q, v1_q, sof1_q, sof2_q;
  logic [IDX_WIDTH-1:0]     sel_bit, dout_bit_d, dout_bit_q;
  logic                     dout_found_d, dout_found_q, dout_valid_q;
  frame_state_e             state_d, state_q;
  logic [CNT_WIDTH-1:0]     cnt_d, cnt_q, hw_d, hw_q, cur, lw;
  logic [IDX_WIDTH-1:0]     hb_d, hb_q, lb;
  logic                     hit_d, hit_q, lh, first, last, take;
  logic [CNT_WIDTH-1:0]     frame_word_d, frame_word_q;
  logic [IDX_WIDTH-1:0]     frame_bit_d, frame_bit_q;
  logic                     frame_found_d, frame_found_q, frame_valid_d, frame_valid_q;
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    seg_priority_encoder #(.W(SEG_WIDTH), .IW(SIW)) u_enc (
      .seg    (din[g*SEG_WIDTH +: SEG_WIDTH]),
      .lsb_idx(lsb_d[g]),
      .msb_idx(msb_d[g]),
      .any    (any_d[g])
    );
  end
  always_comb begin
    sel_bit = '0;
    for (int i = NSEG - 1; i >= 0; i--)
      sel_bit = (any_q[i] && mode_q == MODE_LSB) ? IDX_WIDTH'(i * SEG_WIDTH) + IDX_WIDTH'(lsb_q[i]) : sel_bit;
    for (int i = 0; i < NSEG; i++)
      sel_bit = (any_q[i] && mode_q == MODE_MSB) ? IDX_WIDTH'(i * SEG_WIDTH) + IDX_WIDTH'(msb_q[i]) : sel_bit;
    dout_bit_d   = v1_q ? sel_bit : dout_bit_q;
    dout_found_d = v1_q ? |any_q : dout_found_q;
  end
  assign cur   = sof2_q ? '0 : cnt_q;
  assign first = dout_found_q && !(hit_q && !sof2_q);
  assign lh    = (hit_q && !sof2_q) || dout_found_q;
  assign lw    = first ? cur : hw_q;
  assign lb    = first ? dout_bit_q : hb_q;
  assign last  = &cur;
  assign take  = dout_valid_q && (sof2_q || state_q == RUN);
  always_comb begin
    state_d       = take ? RUN : state_q;
    cnt_d         = take ? cur + CNT_WIDTH'(1) : cnt_q;
    hit_d         = take ? lh && !last : hit_q;
    hw_d          = take ? lw : hw_q;
    hb_d          = take ? lb : hb_q;
    frame_valid_d = take && last;
    frame_found_d = frame_valid_d ? lh : frame_found_q;
    frame_word_d  = frame_valid_d ? (lh ? lw : '0) : frame_word_q;
    frame_bit_d   = frame_valid_d ? (lh ? lb : '0) : frame_bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_q         <= '0;
      msb_q         <= '0;
      any_q         <= '0;
      mode_q        <= MODE_LSB;
      v1_q          <= 1'b0;
      sof1_q        <= 1'b0;
      sof2_q        <= 1'b0;
      dout_bit_q    <= '0;
      dout_found_q  <= 1'b0;
      dout_valid_q  <= 1'b0;
      state_q       <= UNALIGNED;
      cnt_q         <= '0;
      hit_q         <= 1'b0;
      hw_q          <= '0;
      hb_q          <= '0;
      frame_word_q  <= '0;
      frame_bit_q   <= '0;
      frame_found_q <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      lsb_q         <= lsb_d;
      msb_q         <= msb_d;
      any_q         <= any_d;
      mode_q        <= msb_first;
      v1_q          <= din_valid;
      sof1_q        <= din_valid & sof;
      sof2_q        <= sof1_q;
      dout_bit_q    <= dout_bit_d;
      dout_found_q  <= dout_found_d;
      dout_valid_q  <= v1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hit_q         <= hit_d;
      hw_q          <= hw_d;
      hb_q          <= hb_d;
      frame_word_q  <= frame_word_d;
      frame_bit_q   <= frame_bit_d;
      frame_found_q <= frame_found_d;
      frame_valid_q <= frame_valid_d;
    end
  end
  assign dout_bit    = dout_bit_q;
  assign dout_found  = dout_found_q;
  assign dout_valid  = dout_valid_q;
  assign frame_word  = frame_word_q;
  assign frame_bit   = frame_bit_q;
  assign frame_found = frame_found_q;
  assign frame_valid = frame_valid_q;
endmodule

// File: tb/tb_first_hit_locator.sv
// tb_first_hit_locator: vector table, frame sequences and random sweep against a word-stream model
module tb_first_hit_locator;
  localparam int DW = 64, SW = 16, FL = 4, IW = 6, CW = 2;
  logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0, msb_first = 1'b0, sof = 1'b0;
  logic [DW-1:0] din = '0;
  logic [IW-1:0] dout_bit, frame_bit;
  logic [CW-1:0] frame_word;
  logic dout_found, dout_valid, frame_found, frame_valid;
  int checks = 0, errors = 0, fv_seen = 0;
  typedef struct {logic v; logic f; logic [IW-1:0] b;} wres_t;
  typedef struct {logic v; logic f; logic [CW-1:0] w; logic [IW-1:0] b;} fres_t;
  typedef struct {logic [DW-1:0] d; logic m; logic [IW-1:0] b; logic f;} vec_t;
  wres_t p1;
  fres_t q1, q2;
  logic [IW-1:0] hold_b, m_hb;
  logic hold_f, m_run, m_hit;
  logic [CW-1:0] m_cnt, m_hw;
  vec_t tab[12];
  first_hit_locator #(.DIN_WIDTH(DW), .SEG_WIDTH(SW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .msb_first(msb_first), .sof(sof),
    .dout_bit(dout_bit), .dout_found(dout_found), .dout_valid(dout_valid),
    .frame_word(frame_word), .frame_bit(frame_bit), .frame_found(frame_found), .frame_valid(frame_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [IW-1:0] ref_bit(input logic [DW-1:0] d, input logic m);
    logic [DW:0] x;
    if (d == '0) return '0;
    x = m ? ({1'b0, d} + 65'd1) : {1'b0, d & (~d + 64'd1)};
    return IW'(m ? $clog2(x) - 1 : $clog2(x));
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step(input logic [DW-1:0] d, input logic v, input logic m, input logic s, input logic r);
    wres_t nw;
    fres_t nf;
    din = d; din_valid = v; msb_first = m; sof = s; rst = r;
    nw.v = v; nw.f = d != '0; nw.b = ref_bit(d, m);
    nf.v = 1'b0; nf.f = 1'b0; nf.w = '0; nf.b = '0;
    if (v && !r) begin
      if (s) begin m_run = 1'b1; m_cnt = '0; m_hit = 1'b0; end
      if (m_run) begin
        if (!m_hit && d != '0) begin m_hit = 1'b1; m_hw = m_cnt; m_hb = ref_bit(d, m); end
        if (m_cnt == CW'(FL - 1)) begin
          nf.v = 1'b1; nf.f = m_hit; nf.w = m_hit ? m_hw : '0; nf.b = m_hit ? m_hb : '0;
          m_hit = 1'b0; m_cnt = '0;
        end else m_cnt = m_cnt + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (frame_valid) fv_seen++;
    if (r) begin
      chk("rst_dout_valid", 64'(dout_valid), 0);
      chk("rst_dout_bit", 64'(dout_bit), 0);
      chk("rst_dout_found", 64'(dout_found), 0);
      chk("rst_frame_valid", 64'(frame_valid), 0);
      chk("rst_frame_word", 64'(frame_word), 0);
      chk("rst_frame_bit", 64'(frame_bit), 0);
      chk("rst_frame_found", 64'(frame_found), 0);
      m_run = 1'b0; m_hit = 1'b0; m_cnt = '0;
      p1.v = 1'b0; q1.v = 1'b0; q2.v = 1'b0; hold_b = '0; hold_f = 1'b0;
    end else begin
      chk("dout_valid", 64'(dout_valid), 64'(p1.v));
      if (p1.v) begin hold_b = p1.b; hold_f = p1.f; end
      chk("dout_bit", 64'(dout_bit), 64'(hold_b));
      chk("dout_found", 64'(dout_found), 64'(hold_f));
      chk("frame_valid", 64'(frame_valid), 64'(q2.v));
      if (q2.v) begin
        chk("frame_word", 64'(frame_word), 64'(q2.w));
        chk("frame_bit", 64'(frame_bit), 64'(q2.b));
        chk("frame_found", 64'(frame_found), 64'(q2.f));
      end
      q2 = q1; q1 = nf; p1 = nw;
    end
  endtask
  task automatic idle();
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic word(input logic [DW-1:0] d, input logic s);
    step(d, 1'b1, 1'b0, s, 1'b0);
  endtask
  initial begin
    int fvs;
    logic [DW-1:0] d;
    tab[0]  = '{64'h0000_0000_0001_0100, 1'b0, 6'd8, 1'b1};
    tab[1]  = '{64'h0000_0000_0001_0100, 1'b1, 6'd16, 1'b1};
    tab[2]  = '{64'h0, 1'b0, 6'd0, 1'b0};
    tab[3]  = '{64'h0, 1'b1, 6'd0, 1'b0};
    tab[4]  = '{64'h8000_0000_0000_0000, 1'b0, 6'd63, 1'b1};
    tab[5]  = '{64'h8000_0000_0000_0001, 1'b1, 6'd63, 1'b1};
    tab[6]  = '{64'h8000_0000_0000_0001, 1'b0, 6'd0, 1'b1};
    tab[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd63, 1'b1};
    tab[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd0, 1'b1};
    tab[9]  = '{64'h0000_0001_0000_8000, 1'b0, 6'd15, 1'b1};
    tab[10] = '{64'h0000_0001_0000_8000, 1'b1, 6'd32, 1'b1};
    tab[11] = '{64'h0010_0000_0000_0000, 1'b0, 6'd52, 1'b1};
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(tab[i].d, 1'b1, tab[i].m, 1'b0, 1'b0);
      if (i > 0) begin
        chk($sformatf("tab%0d_bit", i - 1), 64'(dout_bit), 64'(tab[i-1].b));
        chk($sformatf("tab%0d_found", i - 1), 64'(dout_found), 64'(tab[i-1].f));
      end
    end
    idle();
    chk("tab11_bit", 64'(dout_bit), 64'(tab[11].b));
    chk("tab11_valid", 64'(dout_valid), 1);
    idle();
    chk("gap_valid", 64'(dout_valid), 0);
    chk("gap_hold_bit", 64'(dout_bit), 52);
    chk("gap_hold_found", 64'(dout_found), 1);
    chk("unaligned_no_fv", 64'(fv_seen), 0);
    word('0, 1'b1); word('0, 1'b0); word(64'h80, 1'b0); word(64'h1, 1'b0);
    idle();
    chk("f1_early", 64'(frame_valid), 0);
    idle();
    chk("f1_valid", 64'(frame_valid), 1);
    chk("f1_word", 64'(frame_word), 2);
    chk("f1_bit", 64'(frame_bit), 7);
    chk("f1_found", 64'(frame_found), 1);
    for (int i = 0; i < 4; i++) word('0, 1'b0);
    idle(); idle();
    chk("f2_valid", 64'(frame_valid), 1);
    chk("f2_found", 64'(frame_found), 0);
    chk("f2_word", 64'(frame_word), 0);
    chk("f2_bit", 64'(frame_bit), 0);
    fvs = fv_seen;
    word(64'h4, 1'b1); word('0, 1'b0); word('0, 1'b1); word(64'h10, 1'b0); word('0, 1'b0); word('0, 1'b0);
    idle(); idle();
    chk("f3_valid", 64'(frame_valid), 1);
    chk("f3_word", 64'(frame_word), 1);
    chk("f3_bit", 64'(frame_bit), 4);
    chk("f3_abandon_count", 64'(fv_seen - fvs), 1);
    word('0, 1'b1); word('0, 1'b0); word('0, 1'b0); word(64'h2, 1'b0);
    word(64'h8, 1'b1);
    idle();
    chk("f4_valid", 64'(frame_valid), 1);
    chk("f4_word", 64'(frame_word), 3);
    chk("f4_bit", 64'(frame_bit), 1);
    chk("f4_found", 64'(frame_found), 1);
    word('0, 1'b0); word('0, 1'b0); word('0, 1'b0);
    idle(); idle();
    chk("f5_valid", 64'(frame_valid), 1);
    chk("f5_word", 64'(frame_word), 0);
    chk("f5_bit", 64'(frame_bit), 3);
    fvs = fv_seen;
    word(64'h1, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) word(64'h1, 1'b0);
    idle(); idle();
    chk("rst_no_fv", 64'(fv_seen - fvs), 0);
    word(64'h100, 1'b1); word('0, 1'b0); word('0, 1'b0); word('0, 1'b0);
    idle(); idle();
    chk("f6_valid", 64'(frame_valid), 1);
    chk("f6_word", 64'(frame_word), 0);
    chk("f6_bit", 64'(frame_bit), 8);
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0: d = 64'd1 << $urandom_range(0, 63);
        1: d = {$urandom, $urandom};
        2: d = '0;
        default: d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      step(d, $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 199) == 0);
    end
    idle(); idle(); idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
